int_ram_pingpong: RTL and testbench

- Parametrised ping-pong store for intrinsic (channel LLR) messages.
- Holds two banks of NUM_LANES single-port RAMs each. The channel loader fills one bank while the decoder reads the other.
- A bank ownership state machine with a start/done handshake to the decoder controls each bank.
- Sits between the channel input stage and the variable-node units.

---
 rtl/int_ram_pkg.sv | 18 +
 rtl/int_ram_pingpong_if.sv | 30 +++
 rtl/RAM_SP_SR_RW.sv | 21 ++
 rtl/int_ram_pingpong.sv | 120 ++++++++++++
 tb/tb_int_ram_pingpong.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/int_ram_pkg.sv
// Shared types and helpers for the intrinsic-message ping-pong store.
package int_ram_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DECODING = 2'd3
  } bank_state_e;

  localparam int NUM_BANKS = 2;

  // Low bit of lane `lane` in a flat vector of `width`-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/int_ram_pingpong_if.sv
// Loader / decoder / read-port bundle for int_ram_pingpong.
interface int_ram_pingpong_if #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_LANES  = 2
) ();
  logic                            wr_valid;
  logic                            wr_ready;
  logic [NUM_LANES*DATA_WIDTH-1:0] wr_data;
  logic                            dec_ready;
  logic                            dec_start;
  logic                            dec_busy;
  logic                            dec_bank;
  logic                            dec_done;
  logic                            rd_en;
  logic [NUM_LANES*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_LANES*DATA_WIDTH-1:0] rd_data;
  logic                            rd_valid;
  logic                            err;

  modport master (
    output wr_valid, wr_data, dec_start, dec_done, rd_en, rd_addr,
    input  wr_ready, dec_ready, dec_busy, dec_bank, rd_data, rd_valid, err
  );

  modport slave (
    input  wr_valid, wr_data, dec_start, dec_done, rd_en, rd_addr,
    output wr_ready, dec_ready, dec_busy, dec_bank, rd_data, rd_valid, err
  );
endinterface

// File: rtl/RAM_SP_SR_RW.sv
// Single-port RAM: synchronous write, registered synchronous read, no reset.
module RAM_SP_SR_RW #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end
endmodule

// File: rtl/int_ram_pingpong.sv
// Two-bank ping-pong store for channel LLRs: loader fills one bank while the
// decoder reads the other; each bank cycles EMPTY->FILLING->FULL->DECODING.
module int_ram_pingpong
  import int_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_LANES  = 2,
  parameter int FRAME_LEN  = RAM_DEPTH
) (
  input logic              clk,
  input logic              rst_n,
  int_ram_pingpong_if.slave bus
);

  typedef struct packed {
    logic                  cs;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
  } ram_req_t;

  bank_state_e                     st [NUM_BANKS];
  logic                            wr_bank, rd_bank, dec_bank_q;
  logic [ADDR_WIDTH-1:0]           wr_ptr;
  logic                            err_q, rd_valid_q, rsel;
  logic [NUM_LANES*DATA_WIDTH-1:0] rd_hold;
  logic [NUM_LANES*DATA_WIDTH-1:0] ram_q [NUM_BANKS];

  logic wr_ready, any_dec, dec_ready;
  logic wr_fire, rd_fire, start_ok, done_ok, err_set, wr_last;

  assign wr_ready  = (st[wr_bank] == EMPTY) || (st[wr_bank] == FILLING);
  assign any_dec   = (st[0] == DECODING) || (st[1] == DECODING);
  assign dec_ready = (st[rd_bank] == FULL) && !any_dec;

  assign wr_fire  = bus.wr_valid && wr_ready;
  assign wr_last  = (wr_ptr == ADDR_WIDTH'(FRAME_LEN - 1));
  assign rd_fire  = bus.rd_en && any_dec;
  assign start_ok = bus.dec_start && dec_ready;
  assign done_ok  = bus.dec_done && any_dec;
  // A start that collides with a legal done is simply dropped, not flagged.
  assign err_set  = (bus.dec_done && !any_dec) ||
                    (bus.dec_start && !dec_ready && !done_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) st[b] <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      dec_bank_q <= 1'b0;
      wr_ptr     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rsel       <= 1'b0;
      rd_hold    <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          st[wr_bank] <= FULL;
          wr_ptr      <= '0;
          wr_bank     <= ~wr_bank;
        end else begin
          st[wr_bank] <= FILLING;
          wr_ptr      <= wr_ptr + 1'b1;
        end
      end
      if (start_ok) begin
        st[rd_bank] <= DECODING;
        dec_bank_q  <= rd_bank;
      end
      if (done_ok) begin
        st[dec_bank_q] <= EMPTY;
        rd_bank        <= ~rd_bank;
      end
      if (err_set) err_q <= 1'b1;
      rd_valid_q <= rd_fire;
      if (rd_fire)    rsel    <= dec_bank_q;
      if (rd_valid_q) rd_hold <= ram_q[rsel];
    end
  end

  // Write and decode banks never coincide, so each lane RAM needs one port.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam logic BSEL = 1'(b);
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      ram_req_t req;
      always_comb begin
        req = '0;
        if (st[b] == DECODING) begin
          req.cs   = rd_fire && (dec_bank_q == BSEL);
          req.we   = 1'b0;
          req.addr = bus.rd_addr[lane_lo(l, ADDR_WIDTH) +: ADDR_WIDTH];
        end else begin
          req.cs   = wr_fire && (wr_bank == BSEL);
          req.we   = req.cs;
          req.addr = wr_ptr;
        end
      end

      RAM_SP_SR_RW #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk  (clk),
        .cs   (req.cs),
        .we   (req.we),
        .addr (req.addr),
        .din  (bus.wr_data[lane_lo(l, DATA_WIDTH) +: DATA_WIDTH]),
        .dout (ram_q[b][lane_lo(l, DATA_WIDTH) +: DATA_WIDTH])
      );
    end
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.dec_ready = dec_ready;
  assign bus.dec_busy  = any_dec;
  assign bus.dec_bank  = dec_bank_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_valid_q ? ram_q[rsel] : rd_hold;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_int_ram_pingpong.sv
// Directed table-driven bench for int_ram_pingpong (2 lanes, 5b data, 8-beat frames).
module tb_int_ram_pingpong;
  localparam int DW = 5;
  localparam int AW = 3;
  localparam int NL = 2;
  localparam int FL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int_ram_pingpong_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LANES(NL)) bus ();

  int_ram_pingpong #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LANES(NL), .FRAME_LEN(FL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        wv;
    logic [9:0]  wd;
    logic        ds;
    logic        dd;
    logic        re;
    logic [5:0]  ra;
    logic [15:0] exp;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int failures = 0;

  // {wr_ready, dec_ready, dec_busy, dec_bank, rd_valid, err, rd_data}
  wire [15:0] obs = {bus.wr_ready, bus.dec_ready, bus.dec_busy, bus.dec_bank,
                     bus.rd_valid, bus.err, bus.rd_data};

  function automatic logic [15:0] ex(input logic wrdy, input logic drdy,
                                     input logic busy, input logic bank,
                                     input logic rv, input logic er,
                                     input logic [9:0] rd);
    return {wrdy, drdy, busy, bank, rv, er, rd};
  endfunction

  task automatic add(input logic wv, input logic [9:0] wd, input logic ds,
                     input logic dd, input logic re, input logic [5:0] ra,
                     input logic [15:0] e);
    vec_t v;
    v.wv = wv; v.wd = wd; v.ds = ds; v.dd = dd; v.re = re; v.ra = ra; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.wr_valid  = v.wv;
    bus.wr_data   = v.wd;
    bus.dec_start = v.ds;
    bus.dec_done  = v.dd;
    bus.rd_en     = v.re;
    bus.rd_addr   = v.ra;
  endtask

  task automatic idle();
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.dec_start = 1'b0;
    bus.dec_done = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] e);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, obs, e);
    end
  endtask

  initial begin
    idle();
    #2;
    check("reset_hold", ex(1, 0, 0, 0, 0, 0, 10'd0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("reset_idle", ex(1, 0, 0, 0, 0, 0, 10'd0));

    // Frame 0 into bank0: lane0 = k, lane1 = 31-k
    for (int k = 0; k < 8; k++)
      add(1, {5'(31 - k), 5'(k)}, 0, 0, 0, 6'd0, ex(1, k == 7, 0, 0, 0, 0, 10'd0));
    // Claim bank0 and read lane addresses (3, 5)
    add(0, 10'd0, 1, 0, 0, 6'd0, ex(1, 0, 1, 0, 0, 0, 10'd0));
    add(0, 10'd0, 0, 0, 1, {3'd5, 3'd3}, ex(1, 0, 1, 0, 1, 0, {5'd26, 5'd3}));
    add(0, 10'd0, 0, 0, 0, 6'd0, ex(1, 0, 1, 0, 0, 0, {5'd26, 5'd3}));
    // Frame 1 into bank1 (all 9), then the 17th beat stalls on decoding bank0
    for (int k = 0; k < 8; k++)
      add(1, {5'd9, 5'd9}, 0, 0, 0, 6'd0, ex(k != 7, 0, 1, 0, 0, 0, {5'd26, 5'd3}));
    add(1, {5'd1, 5'd2}, 0, 0, 0, 6'd0, ex(0, 0, 1, 0, 0, 0, {5'd26, 5'd3}));
    add(1, {5'd1, 5'd2}, 0, 1, 0, 6'd0, ex(1, 1, 0, 0, 0, 0, {5'd26, 5'd3}));
    add(1, {5'd1, 5'd2}, 1, 0, 0, 6'd0, ex(1, 0, 1, 1, 0, 0, {5'd26, 5'd3}));
    add(0, 10'd0, 0, 0, 1, {3'd2, 3'd7}, ex(1, 0, 1, 1, 1, 0, {5'd9, 5'd9}));
    // Finish bank0: addr a gets lane0 = a, lane1 = 20+a
    for (int a = 1; a < 8; a++)
      add(1, {5'(20 + a), 5'(a)}, 0, 0, 0, 6'd0, ex(a != 7, 0, 1, 1, 0, 0, {5'd9, 5'd9}));
    // done + start together: start dropped without err
    add(0, 10'd0, 1, 1, 0, 6'd0, ex(1, 1, 0, 1, 0, 0, {5'd9, 5'd9}));
    add(0, 10'd0, 1, 0, 0, 6'd0, ex(1, 0, 1, 0, 0, 0, {5'd9, 5'd9}));
    add(0, 10'd0, 0, 0, 1, {3'd7, 3'd0}, ex(1, 0, 1, 0, 1, 0, {5'd27, 5'd2}));
    // Release, idle read, then illegal done -> sticky err
    add(0, 10'd0, 0, 1, 0, 6'd0, ex(1, 0, 0, 0, 0, 0, {5'd27, 5'd2}));
    add(0, 10'd0, 0, 0, 1, 6'd0, ex(1, 0, 0, 0, 0, 0, {5'd27, 5'd2}));
    add(0, 10'd0, 0, 1, 0, 6'd0, ex(1, 0, 0, 0, 0, 1, {5'd27, 5'd2}));
    add(0, 10'd0, 0, 0, 0, 6'd0, ex(1, 0, 0, 0, 0, 1, {5'd27, 5'd2}));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      step();
      check($sformatf("vec%0d", i), vq[i].exp);
    end
    idle();

    // Partial frame into bank1, then asynchronous reset between edges
    for (int k = 0; k < 4; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = {5'(k), 5'(k)};
      step();
    end
    idle();
    check("partial", ex(1, 0, 0, 0, 0, 1, {5'd27, 5'd2}));
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", ex(1, 0, 0, 0, 0, 0, 10'd0));
    @(negedge clk);
    rst_n = 1'b1;

    // Start with nothing FULL -> err
    bus.dec_start = 1'b1;
    step();
    idle();
    check("start_err", ex(1, 0, 0, 0, 0, 1, 10'd0));

    // Fresh frame lands in bank0 from address 0: lane0 = 10+k, lane1 = k
    for (int k = 0; k < 8; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = {5'(k), 5'(10 + k)};
      step();
    end
    idle();
    check("refill", ex(1, 1, 0, 0, 0, 1, 10'd0));
    bus.dec_start = 1'b1;
    step();
    idle();
    check("refill_start", ex(1, 0, 1, 0, 0, 1, 10'd0));
    bus.rd_en = 1'b1; bus.rd_addr = {3'd7, 3'd0};
    step();
    check("refill_rd0", ex(1, 0, 1, 0, 1, 1, {5'd7, 5'd10}));
    bus.rd_addr = {3'd0, 3'd7};
    step();
    idle();
    check("refill_rd1", ex(1, 0, 1, 0, 1, 1, {5'd0, 5'd17}));
    step();
    check("refill_hold", ex(1, 0, 1, 0, 0, 1, {5'd0, 5'd17}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
